display_frame_arbiter: RTL and testbench

//  Shares the 8-digit seven-segment display between two frame sources:

---
 rtl/sonic_display_pkg.sv | 32 +++
 rtl/display_frame_arbiter_sat_counter.sv | 32 +++
 rtl/display_frame_arbiter.sv | 122 ++++++++++++
 tb/tb_display_frame_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sonic_display_pkg.sv
// Shared frame and arbiter-state types for the sonar display path.
// No timing of its own; pack_frame only bundles the raw payload fields.
package sonic_display_pkg;

  typedef struct packed {
    logic [15:0]        distance;
    logic [15:0]        velocity;
    logic               towards;
    logic signed [7:0]  angle;
  } display_frame_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    DWELL = 2'd2
  } arb_state_t;

  function automatic display_frame_t pack_frame(
    input logic [15:0] distance,
    input logic [15:0] velocity,
    input logic        towards,
    input logic [7:0]  angle
  );
    display_frame_t f;
    f.distance = distance;
    f.velocity = velocity;
    f.towards  = towards;
    f.angle    = $signed(angle);
    return f;
  endfunction

endpackage

// File: rtl/display_frame_arbiter_sat_counter.sv
// Saturating up-counter with a registered at-max flag; clr wins over inc.
// The flag updates on the same edge as the count, with no backpressure.
module sat_counter #(
  parameter int MAX = 1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] PRE_V = (MAX == 0) ? '0 : W'(MAX - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt    <= '0;
      at_max <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      at_max <= (MAX_V == '0);
    end else if (inc && !at_max) begin
      cnt    <= cnt + W'(1);
      at_max <= (cnt == PRE_V);
    end
  end

endmodule

// File: rtl/display_frame_arbiter.sv
// Picks alert or measurement frames for the display; outputs land 1 cycle after handshake.
// Readys only rise in ARB, so each source stalls for the whole dwell of the previous frame.
module display_frame_arbiter
  import sonic_display_pkg::*;
#(
  parameter int DWELL_CYCLES  = 25_000_000,
  parameter int MAX_ALERT_RUN = 3,
  parameter int STALE_CYCLES  = 100_000_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        m_valid_in,
  output logic        m_ready_out,
  input  logic [15:0] m_distance_in,
  input  logic [15:0] m_velocity_in,
  input  logic        m_towards_in,
  input  logic [7:0]  m_angle_in,
  input  logic        a_valid_in,
  output logic        a_ready_out,
  input  logic [15:0] a_distance_in,
  input  logic [15:0] a_velocity_in,
  input  logic        a_towards_in,
  input  logic [7:0]  a_angle_in,
  output logic [15:0] distance_out,
  output logic [15:0] velocity_out,
  output logic        towards_out,
  output logic [7:0]  angle_out,
  output logic        src_alert_out,
  output logic        trigger_out,
  output logic        frame_strobe_out,
  output logic        stale_out
);

  arb_state_t     state;
  display_frame_t frame_q;
  display_frame_t m_frame;
  display_frame_t a_frame;
  logic           first_done;
  logic           run_at_max;
  logic           dwell_done;
  logic           grant_a;
  logic           grant_m;
  logic           hs_a;
  logic           hs_m;
  logic           hs;

  assign m_frame = pack_frame(m_distance_in, m_velocity_in, m_towards_in, m_angle_in);
  assign a_frame = pack_frame(a_distance_in, a_velocity_in, a_towards_in, a_angle_in);

  // Alerts win ties until they have taken MAX_ALERT_RUN commits in a row.
  assign grant_a = a_valid_in & (~m_valid_in | ~run_at_max);
  assign grant_m = m_valid_in & ~grant_a;

  assign a_ready_out = (state == ARB) & grant_a;
  assign m_ready_out = (state == ARB) & grant_m;

  assign hs_a = a_valid_in & a_ready_out;
  assign hs_m = m_valid_in & m_ready_out;
  assign hs   = hs_a | hs_m;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= IDLE;
      frame_q          <= '0;
      src_alert_out    <= 1'b0;
      trigger_out      <= 1'b0;
      frame_strobe_out <= 1'b0;
      first_done       <= 1'b0;
    end else begin
      trigger_out      <= 1'b0;
      frame_strobe_out <= 1'b0;
      case (state)
        IDLE: state <= ARB;
        ARB: begin
          if (hs) begin
            state            <= DWELL;
            frame_q          <= hs_a ? a_frame : m_frame;
            src_alert_out    <= hs_a;
            frame_strobe_out <= 1'b1;
            trigger_out      <= ~first_done;
            first_done       <= 1'b1;
          end
        end
        DWELL: begin
          if (dwell_done) state <= ARB;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign distance_out = frame_q.distance;
  assign velocity_out = frame_q.velocity;
  assign towards_out  = frame_q.towards;
  assign angle_out    = $unsigned(frame_q.angle);

  // Cleared by the handshake itself, so the count is 0 on the first DWELL cycle.
  sat_counter #(.MAX(DWELL_CYCLES - 1)) u_dwell (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (hs),
    .inc    (state == DWELL),
    .at_max (dwell_done)
  );

  sat_counter #(.MAX(STALE_CYCLES)) u_stale (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (hs_m),
    .inc    (1'b1),
    .at_max (stale_out)
  );

  sat_counter #(.MAX(MAX_ALERT_RUN)) u_alert_run (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (hs_m),
    .inc    (hs_a),
    .at_max (run_at_max)
  );

endmodule

// File: tb/tb_display_frame_arbiter.sv
// Random and directed stimulus against a cycle-count reference model of the arbiter.
module tb_display_frame_arbiter;
  import sonic_display_pkg::*;

  localparam int DW = 4;
  localparam int MR = 2;
  localparam int ST = 20;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        m_valid_in = 1'b0, a_valid_in = 1'b0;
  logic        m_ready_out, a_ready_out;
  logic [15:0] m_distance_in = '0, m_velocity_in = '0, a_distance_in = '0, a_velocity_in = '0;
  logic        m_towards_in = 1'b0, a_towards_in = 1'b0;
  logic [7:0]  m_angle_in = '0, a_angle_in = '0;
  logic [15:0] distance_out, velocity_out;
  logic        towards_out, src_alert_out, trigger_out, frame_strobe_out, stale_out;
  logic [7:0]  angle_out;

  display_frame_arbiter #(.DWELL_CYCLES(DW), .MAX_ALERT_RUN(MR), .STALE_CYCLES(ST)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .m_valid_in(m_valid_in), .m_ready_out(m_ready_out),
    .m_distance_in(m_distance_in), .m_velocity_in(m_velocity_in),
    .m_towards_in(m_towards_in), .m_angle_in(m_angle_in),
    .a_valid_in(a_valid_in), .a_ready_out(a_ready_out),
    .a_distance_in(a_distance_in), .a_velocity_in(a_velocity_in),
    .a_towards_in(a_towards_in), .a_angle_in(a_angle_in),
    .distance_out(distance_out), .velocity_out(velocity_out),
    .towards_out(towards_out), .angle_out(angle_out),
    .src_alert_out(src_alert_out), .trigger_out(trigger_out),
    .frame_strobe_out(frame_strobe_out), .stale_out(stale_out)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: edges counted since reset release, commit spacing by arithmetic.
  int             edge_no;
  int             last_commit;
  int             alert_run;
  int             meas_age;
  bit             first_done;
  display_frame_t exp_f;
  bit             exp_src, exp_trig, exp_strobe;
  bit             m_acc, a_acc;
  bit             log_en = 1'b0;
  bit             src_log[$];

  task automatic model_reset();
    edge_no     = 0;
    last_commit = 1 - DW;
    alert_run   = 0;
    meas_age    = 0;
    first_done  = 1'b0;
    exp_f       = '0;
    exp_src     = 1'b0;
    exp_trig    = 1'b0;
    exp_strobe  = 1'b0;
    m_acc       = 1'b0;
    a_acc       = 1'b0;
  endtask

  function automatic display_frame_t rand_frame();
    display_frame_t f;
    f.distance = 16'($urandom);
    f.velocity = 16'($urandom);
    f.towards  = 1'($urandom);
    f.angle    = 8'($urandom);
    return f;
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic mv, input display_frame_t mf,
                      input logic av, input display_frame_t af);
    int x;
    bit open, ga, gm;
    chk("distance", 32'(distance_out), 32'(exp_f.distance));
    chk("velocity", 32'(velocity_out), 32'(exp_f.velocity));
    chk("towards", 32'(towards_out), 32'(exp_f.towards));
    chk("angle", 32'(angle_out), 32'($unsigned(exp_f.angle)));
    chk("src_alert", 32'(src_alert_out), 32'(exp_src));
    chk("trigger", 32'(trigger_out), 32'(exp_trig));
    chk("strobe", 32'(frame_strobe_out), 32'(exp_strobe));
    chk("stale", 32'(stale_out), 32'(meas_age >= ST));
    if (log_en && frame_strobe_out) src_log.push_back(src_alert_out);

    m_valid_in = mv; m_distance_in = mf.distance; m_velocity_in = mf.velocity;
    m_towards_in = mf.towards; m_angle_in = $unsigned(mf.angle);
    a_valid_in = av; a_distance_in = af.distance; a_velocity_in = af.velocity;
    a_towards_in = af.towards; a_angle_in = $unsigned(af.angle);
    #1;
    x    = edge_no + 1;
    open = (x >= 2) && (x - last_commit >= DW + 1);
    ga   = open && av && (!mv || alert_run < MR);
    gm   = open && mv && !ga;
    chk("m_ready", 32'(m_ready_out), 32'(gm));
    chk("a_ready", 32'(a_ready_out), 32'(ga));

    exp_strobe = 1'b0;
    exp_trig   = 1'b0;
    if (ga || gm) begin
      exp_f       = ga ? af : mf;
      exp_src     = ga;
      exp_strobe  = 1'b1;
      exp_trig    = !first_done;
      first_done  = 1'b1;
      last_commit = x;
      alert_run   = ga ? ((alert_run < MR) ? alert_run + 1 : MR) : 0;
    end
    if (gm) meas_age = 0;
    else if (meas_age < ST) meas_age++;
    edge_no = x;
    m_acc = gm;
    a_acc = ga;
    @(negedge clk_in);
  endtask

  initial begin
    display_frame_t zf, mf, af;
    logic mv, av;
    int trig_seen;
    bit pat [6];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    zf = '0;

    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_dist", 32'(distance_out), 32'h0);
    chk("rst_strobe", 32'(frame_strobe_out), 32'h0);
    chk("rst_stale", 32'(stale_out), 32'h0);
    chk("rst_m_ready", 32'(m_ready_out), 32'h0);
    rst_in = 1'b0;
    model_reset();

    // First measurement offered on cycle 5
    repeat (4) step(1'b0, zf, 1'b0, zf);
    mf = zf; mf.distance = 16'h0123;
    step(1'b1, mf, 1'b0, zf);
    chk("first_dist", 32'(distance_out), 32'h0123);
    chk("first_trig", 32'(trigger_out), 32'h1);
    chk("first_strobe", 32'(frame_strobe_out), 32'h1);

    // Continuous measurements
    repeat (25) step(1'b1, rand_frame(), 1'b0, zf);

    // Both sources continuously valid: alert, alert, meas, ...
    repeat (6) step(1'b0, zf, 1'b0, zf);
    log_en = 1'b1;
    repeat (33) step(1'b1, rand_frame(), 1'b1, rand_frame());
    log_en = 1'b0;
    chk("alt_count_ok", 32'(src_log.size() >= 6), 32'h1);
    for (int i = 0; i < 6 && i < src_log.size(); i++)
      chk($sformatf("alt_seq%0d", i), 32'(src_log[i]), 32'(pat[i]));

    // Starvation of measurements -> stale
    repeat (24) step(1'b0, zf, 1'b0, zf);
    chk("stale_set", 32'(stale_out), 32'h1);
    mf = rand_frame();
    step(1'b1, mf, 1'b0, zf);
    chk("stale_clr", 32'(stale_out), 32'h0);

    // Alert with negative angle
    repeat (6) step(1'b0, zf, 1'b0, zf);
    af = rand_frame(); af.angle = -8'sd45;
    step(1'b0, zf, 1'b1, af);
    chk("neg_angle", 32'(angle_out), 32'hD3);
    chk("neg_src", 32'(src_alert_out), 32'h1);

    // Reset asserted mid-dwell
    repeat (2) step(1'b0, zf, 1'b0, zf);
    mf = rand_frame(); mf.distance = 16'hBEEF;
    step(1'b1, mf, 1'b0, zf);
    step(1'b0, zf, 1'b0, zf);
    #2 rst_in = 1'b1;
    #1;
    chk("mid_rst_dist", 32'(distance_out), 32'h0);
    chk("mid_rst_src", 32'(src_alert_out), 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    trig_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, mf, 1'b0, zf);
      if (trigger_out) trig_seen++;
    end
    chk("retrigger", 32'(trig_seen), 32'h1);

    // Randomized traffic; sources hold until accepted
    mv = 1'b0; av = 1'b0; mf = zf; af = zf;
    for (int i = 0; i < 400; i++) begin
      if (!(mv && !m_acc)) begin
        mv = ($urandom_range(0, 3) == 0);
        mf = rand_frame();
      end
      if (!(av && !a_acc)) begin
        av = ($urandom_range(0, 2) == 0);
        af = rand_frame();
      end
      step(mv, mf, av, af);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
